// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared video header constants and the helpers used to step the sprite position.
// The sync generator reads the same VID_* constants.
package sprite_motion_ctrl_pkg;

  localparam int VID_H_DISPLAY   = 640;
  localparam int VID_V_DISPLAY   = 480;
  localparam int VID_SPRITE_SIZE = 16;
  localparam int POS_W           = 10;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    MOVE_HOLD = 2'd0,
    MOVE_DEC  = 2'd1,
    MOVE_INC  = 2'd2
  } move_e;

  // Opposing buttons pressed together cancel out.
  function automatic move_e moveDir(input logic dec, input logic inc);
    move_e dir;
    dir = MOVE_HOLD;
    if (dec && !inc) begin
      dir = MOVE_DEC;
    end else if (inc && !dec) begin
      dir = MOVE_INC;
    end
    return dir;
  endfunction

  function automatic pos_t stepPos(input pos_t pos, input move_e dir, input pos_t maxPos);
    pos_t nextPos;
    nextPos = pos;
    case (dir)
      MOVE_DEC: if (pos != '0)    nextPos = pos - 1'b1;
      MOVE_INC: if (pos < maxPos) nextPos = pos + 1'b1;
      default:  nextPos = pos;
    endcase
    return nextPos;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One joystick button: 2-flop synchronizer followed by a stable-count debouncer.
module button_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_state
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_state;
  logic [CNT_W-1:0] r_count;

  // The counter only advances while the synchronized input disagrees with the
  // accepted state; a single agreeing cycle starts the wait over.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_state) begin
        r_count <= '0;
      end else if (r_count == CNT_LAST) begin
        r_state <= r_sync2;
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Joystick-driven sprite position: debounced buttons move a working position on a
// fixed tick, and the displayed position is only refreshed on the vsync rising edge.
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int H_DISPLAY   = VID_H_DISPLAY,
  parameter int V_DISPLAY   = VID_V_DISPLAY,
  parameter int SPRITE_SIZE = VID_SPRITE_SIZE,
  parameter int TICK_DIV    = 250000,
  parameter int DB_CYCLES   = 250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_left,
  input  logic             i_right,
  input  logic             i_up,
  input  logic             i_down,
  input  logic             i_vsync,
  input  logic [POS_W-1:0] i_hpos,
  input  logic [POS_W-1:0] i_vpos,
  output logic [POS_W-1:0] o_playerX,
  output logic [POS_W-1:0] o_playerY,
  output logic             o_hstart,
  output logic             o_vstart,
  output logic [3:0]       o_led
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam pos_t MAX_X   = pos_t'(H_DISPLAY - SPRITE_SIZE);
  localparam pos_t MAX_Y   = pos_t'(V_DISPLAY - SPRITE_SIZE);
  localparam pos_t RESET_X = pos_t'(H_DISPLAY / 2);
  localparam pos_t RESET_Y = pos_t'(V_DISPLAY / 2);

  // Bit order matches the led output: {up, down, left, right}.
  logic [3:0]        w_raw;
  logic [3:0]        w_deb;
  logic              w_tick;
  logic              w_vsyncRise;
  logic [TICK_W-1:0] r_tickCnt;
  logic              r_vsyncD;
  pos_t              r_joyX;
  pos_t              r_joyY;
  pos_t              r_playerX;
  pos_t              r_playerY;
  logic [3:0]        r_led;

  assign w_raw = {i_up, i_down, i_left, i_right};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    button_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (w_raw[g]),
      .o_state(w_deb[g])
    );
  end

  assign w_tick      = (r_tickCnt == TICK_LAST);
  assign w_vsyncRise = i_vsync && !r_vsyncD;

  always_ff @(posedge clk) begin
    if (reset || w_tick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + 1'b1;
    end
  end

  // Nonblocking update means a vsync edge on a tick cycle latches the pre-tick value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_joyX    <= RESET_X;
      r_joyY    <= RESET_Y;
      r_playerX <= RESET_X;
      r_playerY <= RESET_Y;
      r_vsyncD  <= 1'b0;
      r_led     <= 4'b0000;
    end else begin
      r_vsyncD <= i_vsync;
      r_led    <= w_deb;
      if (w_tick) begin
        r_joyX <= stepPos(r_joyX, moveDir(w_deb[1], w_deb[0]), MAX_X);
        r_joyY <= stepPos(r_joyY, moveDir(w_deb[3], w_deb[2]), MAX_Y);
      end
      if (w_vsyncRise) begin
        r_playerX <= r_joyX;
        r_playerY <= r_joyY;
      end
    end
  end

  assign o_playerX = r_playerX;
  assign o_playerY = r_playerY;
  assign o_hstart  = (i_hpos == r_playerX);
  assign o_vstart  = (i_vpos == r_playerY);
  assign o_led     = r_led;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: directed scenarios plus random button and
// vsync traffic, scored every cycle against a behavioural model of the movement rules.
module tb_sprite_motion_ctrl;

  localparam int TD   = 4;
  localparam int DB   = 3;
  localparam int HD   = 640;
  localparam int VD   = 480;
  localparam int SS   = 16;
  localparam int MAXX = HD - SS;
  localparam int MAXY = VD - SS;

  localparam logic [3:0] B_RIGHT = 4'b0001;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_UP    = 4'b1000;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn   = 4'b0000;
  logic       vsync = 1'b0;
  logic [9:0] hpos  = '0;
  logic [9:0] vpos  = '0;
  logic [9:0] playerX;
  logic [9:0] playerY;
  logic       hstart;
  logic       vstart;
  logic [3:0] led;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sprite_motion_ctrl #(
    .TICK_DIV (TD),
    .DB_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_left   (btn[1]),
    .i_right  (btn[0]),
    .i_up     (btn[3]),
    .i_down   (btn[2]),
    .i_vsync  (vsync),
    .i_hpos   (hpos),
    .i_vpos   (vpos),
    .o_playerX(playerX),
    .o_playerY(playerY),
    .o_hstart (hstart),
    .o_vstart (vstart),
    .o_led    (led)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: buttons index 0..3 = right, left, down, up.
  typedef struct {
    int px;
    int py;
    int led;
  } exp_t;

  exp_t expQ[$];
  int   mS1[4]  = '{default: 0};
  int   mS2[4]  = '{default: 0};
  int   mDeb[4] = '{default: 0};
  int   mRun[4] = '{default: 0};
  int   mPhase  = 0;
  int   mJoyX   = HD / 2;
  int   mJoyY   = VD / 2;
  int   mPx     = HD / 2;
  int   mPy     = VD / 2;
  int   mLed    = 0;
  int   mVsPrev = 0;
  bit   mTick   = 1'b0;

  function automatic int clampInt(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  always @(posedge clk) begin : refModel
    int   dx;
    int   dy;
    exp_t e;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mS1[i] = 0; mS2[i] = 0; mDeb[i] = 0; mRun[i] = 0;
      end
      mPhase = 0; mJoyX = HD / 2; mJoyY = VD / 2;
      mPx = HD / 2; mPy = VD / 2; mLed = 0; mVsPrev = 0; mTick = 1'b0;
    end else begin
      if (vsync && mVsPrev == 0) begin
        mPx = mJoyX;
        mPy = mJoyY;
      end
      mVsPrev = vsync ? 1 : 0;
      mTick   = (mPhase == TD - 1);
      mPhase  = (mPhase + 1) % TD;
      if (mTick) begin
        dx    = mDeb[0] - mDeb[1];
        dy    = mDeb[2] - mDeb[3];
        mJoyX = clampInt(mJoyX + dx, MAXX);
        mJoyY = clampInt(mJoyY + dy, MAXY);
      end
      mLed = 8 * mDeb[3] + 4 * mDeb[2] + 2 * mDeb[1] + mDeb[0];
      for (int i = 0; i < 4; i++) begin
        if (mS2[i] != mDeb[i]) begin
          mRun[i]++;
          if (mRun[i] == DB) begin
            mDeb[i] = mS2[i];
            mRun[i] = 0;
          end
        end else begin
          mRun[i] = 0;
        end
        mS2[i] = mS1[i];
        mS1[i] = btn[i] ? 1 : 0;
      end
    end
    e.px  = mPx;
    e.py  = mPy;
    e.led = mLed;
    expQ.push_back(e);
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("sb_playerX", int'(playerX), e.px);
      checkOutput("sb_playerY", int'(playerY), e.py);
      checkOutput("sb_led", int'(led), e.led);
      checkOutput("sb_hstart", int'(hstart), (int'(hpos) == e.px) ? 1 : 0);
      checkOutput("sb_vstart", int'(vstart), (int'(vpos) == e.py) ? 1 : 0);
    end
  end

  bit         posFixed = 1'b0;
  logic [9:0] fixH     = '0;
  logic [9:0] fixV     = '0;

  always @(posedge clk) begin : beamDriver
    #2;
    if (posFixed) begin
      hpos = fixH;
      vpos = fixV;
    end else begin
      hpos = ($urandom_range(0, 3) == 0) ? 10'(mPx) : 10'($urandom_range(0, 1023));
      vpos = ($urandom_range(0, 3) == 0) ? 10'(mPy) : 10'($urandom_range(0, 1023));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic vs, input int n);
    btn   = b;
    vsync = vs;
    step(n);
  endtask

  task automatic doReset();
    reset = 1'b1;
    vsync = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic waitDeb(input logic [3:0] mask);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      step(1);
      done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (mask[i] && mDeb[i] != 1) done = 1'b0;
      end
    end
    if (!done) checkOutput("waitDeb_timeout", 0, 1);
  endtask

  task automatic waitTicks(input int n);
    int got;
    got = 0;
    for (int c = 0; c < TD * n + 8 && got < n; c++) begin
      step(1);
      if (mTick) got++;
    end
    if (got < n) checkOutput("waitTicks_timeout", got, n);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainFlow
    int  seen;
    int  waitCnt;
    step(1);
    doReset();

    // Reset values and the combinational start strobes
    checkOutput("rst_playerX", int'(playerX), 320);
    checkOutput("rst_playerY", int'(playerY), 240);
    checkOutput("rst_led", int'(led), 0);
    posFixed = 1'b1;
    fixH = 10'd320;
    fixV = 10'd240;
    @(negedge clk);
    checkOutput("rst_hstart_hit", int'(hstart), 1);
    checkOutput("rst_vstart_hit", int'(vstart), 1);
    fixH = 10'd321;
    fixV = 10'd239;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_hstart_miss", int'(hstart), 0);
    checkOutput("rst_vstart_miss", int'(vstart), 0);
    posFixed = 1'b0;
    step(1);

    // Right held for 12 movement ticks, then a long vsync pulse
    btn = B_RIGHT;
    waitDeb(B_RIGHT);
    waitTicks(12);
    checkOutput("right12_before_edge", int'(playerX), 320);
    applyStimulus(B_RIGHT, 1'b1, 1);
    checkOutput("right12_after_edge", int'(playerX), 332);
    checkOutput("right12_y", int'(playerY), 240);
    applyStimulus(B_RIGHT, 1'b1, 2);
    applyStimulus(B_RIGHT, 1'b0, 2);

    // Reset while still holding right
    doReset();
    checkOutput("midhold_reset_x", int'(playerX), 320);
    checkOutput("midhold_reset_y", int'(playerY), 240);

    // Glitch filtering: 2-cycle left press must be ignored, 3-cycle press accepted
    applyStimulus(4'b0000, 1'b0, 10);
    applyStimulus(B_LEFT, 1'b0, 2);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b0000, 1'b0, 1);
      if (led[1]) seen = 1;
    end
    checkOutput("glitch2_led_left", seen, 0);
    applyStimulus(4'b0000, 1'b1, 1);
    checkOutput("glitch2_joyX", int'(playerX), 320);
    applyStimulus(4'b0000, 1'b0, 1);
    applyStimulus(B_LEFT, 1'b0, 3);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b0000, 1'b0, 1);
      if (led[1]) seen = 1;
    end
    checkOutput("hold3_led_left", seen, 1);

    // Left and right cancel while up moves the sprite upward
    doReset();
    btn = B_LEFT | B_RIGHT | B_UP;
    waitDeb(B_LEFT | B_RIGHT | B_UP);
    waitTicks(4);
    applyStimulus(B_LEFT | B_RIGHT | B_UP, 1'b1, 1);
    checkOutput("lr_cancel_x", int'(playerX), 320);
    checkOutput("up4_y", int'(playerY), 236);
    applyStimulus(B_LEFT | B_RIGHT | B_UP, 1'b0, 1);

    // Saturation at right and top edges
    doReset();
    btn = B_RIGHT | B_UP;
    waitTicks(330);
    applyStimulus(B_RIGHT | B_UP, 1'b1, 1);
    checkOutput("sat_right_x", int'(playerX), MAXX);
    checkOutput("sat_top_y", int'(playerY), 0);
    applyStimulus(B_RIGHT | B_UP, 1'b0, 1);
    waitTicks(5);
    applyStimulus(B_RIGHT | B_UP, 1'b1, 1);
    checkOutput("sat_hold_x", int'(playerX), MAXX);
    checkOutput("sat_hold_y", int'(playerY), 0);
    applyStimulus(4'b0000, 1'b0, 1);

    // vsync edge landing on a tick latches the pre-tick position
    doReset();
    btn = B_RIGHT;
    waitDeb(B_RIGHT);
    waitTicks(2);
    waitCnt = 0;
    while (mPhase != TD - 1 && waitCnt < 10) begin
      step(1);
      waitCnt++;
    end
    if (mPhase != TD - 1) checkOutput("phase_align_timeout", mPhase, TD - 1);
    applyStimulus(B_RIGHT, 1'b1, 1);
    checkOutput("coincide_pretick_x", int'(playerX), 322);
    applyStimulus(B_RIGHT, 1'b0, 1);
    applyStimulus(B_RIGHT, 1'b1, 1);
    checkOutput("coincide_next_edge_x", int'(playerX), 323);
    applyStimulus(4'b0000, 1'b0, 2);

    // Random button, vsync and reset traffic, scored cycle by cycle
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 39) == 0) doReset();
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
                    int'($urandom_range(1, 8)));
    end

    applyStimulus(4'b0000, 1'b0, 3);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
